conv_sched: RTL

//  Layer scheduler for the conv1 -> buffer -> conv2 chain. On start, it fires one

---
 rtl/conv_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/conv_sched.sv
// conv_sched: layer scheduler for the conv1 -> buffer -> conv2 chain.
// It issues one conv1 trigger per channel, drives the weight-bank channel
// select, counts conv2 results, gates the output accumulator and pulses done
// once every channel has produced its conv2 output.
// Optional feature macro: CONV_SCHED_TIMEOUT_EN (WAIT1/DRAIN watchdog).
// Handshakes: conv1_valid/conv2_valid are single-cycle strobes with no
// back-pressure; each strobe is consumed in the cycle it is high.
// state_dbg exposes the FSM state for checkers.
module conv_sched #(
  parameter int CHAN        = 10,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       conv_trigger,
  output logic [3:0] wsel_chan,
  input  logic       conv1_valid,
  input  logic [3:0] conv1_chan,
  input  logic       conv2_valid,
  input  logic [3:0] conv2_chan,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [3:0]  CHAN_LAST = 4'(CHAN - 1);
  localparam logic [4:0]  CHAN_N    = 5'(CHAN);
  localparam logic [7:0]  GAP_LAST  = 8'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT_CYC - 1);

  logic [2:0] state;
  logic [3:0] chan;
  logic [4:0] out_cnt;
  logic [7:0] gap_cnt;
  logic       err_q;
  logic       acc_clr_q;
  logic       timeout;
  logic       start_ok;

  assign start_ok = (state == S_IDLE) && start;

`ifdef CONV_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        waiting;
  logic        activity;

  assign waiting  = (state == S_WAIT1) || (state == S_DRAIN);
  assign activity = conv1_valid || conv2_valid;
  assign timeout  = waiting && !activity && (wd_cnt == WD_LAST);

  // Watchdog: counts silent cycles while waiting, reloads on any completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= 16'd0;
    end else if (!waiting || activity) begin
      wd_cnt <= 16'd0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^WD_LAST;
  assign timeout       = 1'b0;
`endif

  // Main sequencer: issue, wait for conv1, gap, then drain conv2 results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      chan    <= 4'd0;
      gap_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ISSUE;
            chan    <= 4'd0;
            gap_cnt <= 8'd0;
          end
        end
        S_ISSUE: state <= S_WAIT1;
        S_WAIT1: begin
          if (timeout) begin
            state <= S_FIN;
          end else if (conv1_valid) begin
            if (chan == CHAN_LAST) begin
              state <= S_DRAIN;
            end else begin
              chan    <= chan + 4'd1;
              gap_cnt <= 8'd0;
              state   <= (GAP_CYC == 0) ? S_ISSUE : S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 8'd0;
            state   <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (timeout || (out_cnt == CHAN_N)) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output counting, accumulator clear and sticky error collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt   <= 5'd0;
      err_q     <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      acc_clr_q <= start_ok;
      if (start_ok) begin
        out_cnt <= 5'd0;
        err_q   <= 1'b0;
      end
      if (conv2_valid) begin
        if ((state == S_IDLE) || (out_cnt == CHAN_N)) begin
          err_q <= 1'b1;
        end else if (busy) begin
          out_cnt <= out_cnt + 5'd1;
          if (conv2_chan != out_cnt[3:0]) err_q <= 1'b1;
        end
      end
      if (conv1_valid && busy && (state != S_WAIT1)) err_q <= 1'b1;
      if (conv1_valid && (state == S_WAIT1) && (conv1_chan != chan)) err_q <= 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign busy         = (state == S_ISSUE) || (state == S_WAIT1) ||
                        (state == S_GAP)   || (state == S_DRAIN);
  assign conv_trigger = (state == S_ISSUE);
  assign wsel_chan    = chan;
  assign done         = (state == S_FIN);
  assign acc_en       = conv2_valid & busy;
  assign acc_clr      = acc_clr_q;
  assign err          = err_q;
  assign state_dbg    = state;

endmodule
